// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [3:0] PC_REG = 4'hF;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic [3:0] dest;
  } slot_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - operand forwarding select from the M and W slots
import hazard_pkg::*;

module fwd_sel (
  input  slot_t      slot_m,
  input  slot_t      slot_w,
  input  logic [3:0] src,
  output fwd_sel_t   sel
);

  logic unused_w_load;
  assign unused_w_load = slot_w.load;

  // M holds the youngest value; a load in M has no data yet and is never a source
  always_comb begin
    sel = FWD_RF;
    if (slot_m.valid && slot_m.wr && !slot_m.load &&
        slot_m.dest == src && src != PC_REG)
      sel = FWD_M;
    else if (slot_w.valid && slot_w.wr && slot_w.dest == src && src != PC_REG)
      sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall, flush and forwarding control for the 5-stage pipeline
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int NREG_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREG_W-1:0] Ra1D,
  input  logic [NREG_W-1:0] Ra2D,
  input  logic [NREG_W-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              BranchTakenE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL - 1);

  slot_t      slot_e, slot_m, slot_w;
  logic [3:0] e_ra1, e_ra2;
  logic [1:0] cnt;
  logic       lduse, stall, bubble;
  fwd_sel_t   fwd_a, fwd_b;

  assign lduse = slot_e.valid && slot_e.load && slot_e.wr && slot_e.dest != PC_REG &&
                 (slot_e.dest == Ra1D || slot_e.dest == Ra2D);
  assign stall  = lduse || cnt != 2'd0;
  assign bubble = stall || BranchTakenE;

  fwd_sel u_fwd_a (.slot_m(slot_m), .slot_w(slot_w), .src(e_ra1), .sel(fwd_a));
  fwd_sel u_fwd_b (.slot_m(slot_m), .slot_w(slot_w), .src(e_ra2), .sel(fwd_b));

  // Reset doubles as the flush of the pipeline registers, which have no reset
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      StallF    = stall && !BranchTakenE;
      StallD    = stall && !BranchTakenE;
      FlushD    = BranchTakenE;
      FlushE    = bubble;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_e <= '0;
      slot_m <= '0;
      slot_w <= '0;
      e_ra1  <= '0;
      e_ra2  <= '0;
      cnt    <= 2'd0;
    end else begin
      slot_w       <= slot_m;
      slot_m       <= slot_e;
      slot_e.valid <= !bubble;
      slot_e.wr    <= RegWriteD;
      slot_e.load  <= MemtoRegD;
      slot_e.dest  <= WA3D;
      e_ra1        <= Ra1D;
      e_ra2        <= Ra2D;
      if (BranchTakenE)
        cnt <= 2'd0;
      else if (lduse && cnt == 2'd0)
        cnt <= STALL_RELOAD;
      else if (cnt != 2'd0)
        cnt <= cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized bench for hazard_ctrl at LOAD_STALL 1, 2 and 3
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Ra1D, Ra2D, WA3D;
  logic       RegWriteD, MemtoRegD, BranchTakenE;
  logic       sf [3];
  logic       sd [3];
  logic       fd [3];
  logic       fe [3];
  logic [1:0] fa [3];
  logic [1:0] fb [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.LOAD_STALL(g + 1), .NREG_W(4)) dut (
      .clk(clk), .reset(reset),
      .Ra1D(Ra1D), .Ra2D(Ra2D), .WA3D(WA3D),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
      .StallF(sf[g]), .StallD(sd[g]), .FlushD(fd[g]), .FlushE(fe[g]),
      .ForwardAE(fa[g]), .ForwardBE(fb[g])
    );
  end

  // Reference: instructions in flight per pipeline stage, plus bubbles still owed
  typedef struct {
    bit       v, wr, ld;
    bit [3:0] d, a, b;
  } ins_t;

  ins_t pe [3];
  ins_t pm [3];
  ins_t pw [3];
  int   owed [3];

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int k, input bit [3:0] src);
    if (src == 4'hF) return 2'd0;
    if (pm[k].v && pm[k].wr && !pm[k].ld && pm[k].d == src) return 2'd2;
    if (pw[k].v && pw[k].wr && pw[k].d == src) return 2'd1;
    return 2'd0;
  endfunction

  task automatic cycle(input bit rst, input bit [3:0] a1, input bit [3:0] a2,
                       input bit [3:0] wa, input bit rw, input bit ld, input bit br);
    bit hz [3];
    bit st [3];
    reset = rst; Ra1D = a1; Ra2D = a2; WA3D = wa;
    RegWriteD = rw; MemtoRegD = ld; BranchTakenE = br;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      string p;
      p = $sformatf("ls%0d_", k + 1);
      hz[k] = pe[k].v && pe[k].ld && pe[k].wr && pe[k].d != 4'hF &&
              (pe[k].d == a1 || pe[k].d == a2);
      st[k] = (hz[k] || owed[k] > 0) && !br;
      if (rst) begin
        check({p, "stallf"}, {1'b0, sf[k]}, 2'd0);
        check({p, "stalld"}, {1'b0, sd[k]}, 2'd0);
        check({p, "flushd"}, {1'b0, fd[k]}, 2'd1);
        check({p, "flushe"}, {1'b0, fe[k]}, 2'd1);
        check({p, "fwda"}, fa[k], 2'd0);
        check({p, "fwdb"}, fb[k], 2'd0);
      end else begin
        check({p, "stallf"}, {1'b0, sf[k]}, {1'b0, st[k]});
        check({p, "stalld"}, {1'b0, sd[k]}, {1'b0, st[k]});
        check({p, "flushd"}, {1'b0, fd[k]}, {1'b0, br});
        check({p, "flushe"}, {1'b0, fe[k]}, {1'b0, st[k] || br});
        if (pe[k].v) begin
          check({p, "fwda"}, fa[k], ref_fwd(k, pe[k].a));
          check({p, "fwdb"}, fb[k], ref_fwd(k, pe[k].b));
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pe[k].v = 0; pm[k].v = 0; pw[k].v = 0;
        owed[k] = 0;
      end else begin
        pw[k] = pm[k];
        pm[k] = pe[k];
        pe[k] = '{v: !(hz[k] || owed[k] > 0 || br), wr: rw, ld: ld, d: wa, a: a1, b: a2};
        if (br)                           owed[k] = 0;
        else if (hz[k] && owed[k] == 0)   owed[k] = k;
        else if (owed[k] > 0)             owed[k] = owed[k] - 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
  endtask

  bit [3:0] regs [5];

  initial begin
    regs = '{4'd1, 4'd2, 4'd3, 4'd4, 4'hF};
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    nops(1);
    // ALU chain: ADD R1; SUB R2,R1,R3; two more readers of R1
    cycle(0, 4'd2, 4'd3, 4'd1, 1, 0, 0);
    cycle(0, 4'd1, 4'd3, 4'd2, 1, 0, 0);
    cycle(0, 4'd1, 4'd0, 4'd6, 1, 0, 0);
    cycle(0, 4'd1, 4'd0, 4'd7, 1, 0, 0);
    nops(3);
    // LDR R4 then ADD R5,R4,R4 held in decode while stalled
    cycle(0, 4'd0, 4'd0, 4'd4, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 4'd4, 4'd4, 4'd5, 1, 0, 0);
    nops(3);
    // branch resolves in the same cycle as a load-use hazard
    cycle(0, 4'd0, 4'd0, 4'd4, 1, 1, 0);
    cycle(0, 4'd4, 4'd4, 4'd5, 1, 0, 1);
    nops(4);
    // R15 as destination of an ALU op and of a load
    cycle(0, 4'd0, 4'd0, 4'hF, 1, 0, 0);
    cycle(0, 4'hF, 4'hF, 4'd5, 1, 0, 0);
    cycle(0, 4'hF, 4'hF, 4'd6, 1, 0, 0);
    cycle(0, 4'd0, 4'd0, 4'hF, 1, 1, 0);
    cycle(0, 4'hF, 4'hF, 4'd5, 1, 0, 0);
    nops(3);
    // reset lands in the middle of a load-use stall
    cycle(0, 4'd0, 4'd0, 4'd4, 1, 1, 0);
    cycle(0, 4'd4, 4'd4, 4'd5, 1, 0, 0);
    cycle(1, 4'd4, 4'd4, 4'd5, 1, 0, 0);
    cycle(1, 4'd4, 4'd4, 4'd5, 1, 0, 0);
    cycle(0, 4'd4, 4'd4, 4'd5, 0, 0, 0);
    nops(4);
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 49) == 0,
            regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage ARM pipeline: Fetch, Decode, Execute, Memory, Writeback.
- Consumes the decode-stage register fields and control bits that the ID/EX register launches, plus branch resolution from Execute.
- Keeps its own shadow scoreboard of in-flight destinations in the E, M and W slots.
- Drives stall, flush and operand-forwarding selects back into fetch, decode and the pipeline registers.

Parameters:
- LOAD_STALL, 1, number of bubble cycles inserted on a load-use hazard (1..3).
- NREG_W, 4, register-specifier width; R15 (all ones) is the PC.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Ra1D  in  4  decode-stage source register A.
- Ra2D  in  4  decode-stage source register B.
- WA3D  in  4  decode-stage destination register.
- RegWriteD  in  1  decode instruction writes a register.
- MemtoRegD  in  1  decode instruction is a load.
- BranchTakenE  in  1  Execute-stage instruction redirects the PC this cycle.
- StallF  out  1  hold the PC.
- StallD  out  1  hold the IF/ID register.
- FlushD  out  1  clear the IF/ID register to a bubble.
- FlushE  out  1  clear the ID/EX register to a bubble.
- ForwardAE  out  2  source select for E operand A: 00 register file, 01 W result, 10 M ALU result.
- ForwardBE  out  2  source select for E operand B, same encoding as ForwardAE.

Behaviour:
- Internal slots E, M, W. Each slot holds {valid, wr, load, dest[3:0]}; slot E additionally holds {ra1, ra2}.
- Every cycle, M moves to W and E moves to M.
- Slot E loads the D fields {1, RegWriteD, MemtoRegD, WA3D, Ra1D, Ra2D} unless a bubble is required; on a bubble, E.valid is cleared.
- Bubble into E when: FlushE is asserted, or a stall is active.
- Load-use hazard (lduse) = E.valid & E.load & E.wr & E.dest != 15 & (E.dest == Ra1D | E.dest == Ra2D).
- Stall counter cnt, width 2:
  - On lduse with cnt == 0: cnt <= LOAD_STALL-1.
  - Else if cnt != 0: cnt <= cnt-1.
- stall = lduse | (cnt != 0). Then StallF = StallD = stall, and FlushE = stall | BranchTakenE.
- Branch handling: FlushD = BranchTakenE. A branch has priority over a stall:
  - StallF = StallD = 0 so the PC loads the branch target.
  - cnt <= 0.
  - FlushE = 1.
- Forwarding for operand A:
  - ForwardAE = 10 if M.valid & M.wr & M.dest == E.ra1 & M.dest != 15.
  - Else 01 if the same match holds on slot W.
  - Else 00.
- ForwardBE is identical using E.ra2. M has priority over W because it holds the youngest value.
- A load in M is never forwarded at 10; the lduse stall guarantees no consumer sits in E in that case.
- Latency: all outputs are combinational from the slot registers and the current D/E inputs. The scoreboard updates on the next rising edge, mirroring the real pipeline registers exactly.
- Reset (synchronous):
  - All slot valid bits are cleared and cnt = 0.
  - While reset is high: FlushD = FlushE = 1, StallF = StallD = 0, ForwardAE = ForwardBE = 00.
  - This clears the pipeline registers, which have no reset of their own.
- Reset mid-stall: cnt is dropped immediately and no further stall cycles occur after reset deasserts.
- The register file is write-first. Therefore, after a multi-cycle stall, a consumer entering E after the producer has left W reads the correct value with select 00.

Decomposition:
- Shared package hazard_pkg:
  - enum fwd_sel_t {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10}.
  - Constant PC_REG = 4'hF.
  - Struct slot_t {valid, wr, load, dest}.
- One sub-module, fwd_sel: purely combinational, {slot M, slot W, src reg} -> fwd_sel_t. Instantiated twice, once for operand A and once for operand B.

Test Plan:
- Back-to-back ALU ops: ADD R1 then SUB R2,R1,R3 -> in the SUB's E cycle ForwardAE = 10. A third op using R1 -> ForwardAE = 01. Fourth op -> 00.
- LDR R4 then ADD R5,R4,R4 with LOAD_STALL = 1 -> StallF = StallD = FlushE = 1 for exactly one cycle. Then ForwardAE = ForwardBE = 01 in the ADD's E cycle.
- Same sequence with LOAD_STALL = 2 -> stall for two consecutive cycles. Then ForwardAE = 00 (value read from the register file).
- BranchTakenE = 1 in the same cycle as lduse -> FlushD = FlushE = 1, StallF = 0, and cnt = 0 on the next cycle.
- Destination R15 written by an ALU op, followed by a reader of R15 -> no stall and ForwardAE = 00.
- Reset asserted during a LOAD_STALL = 3 stall -> FlushD = FlushE = 1 while reset is high. After release: no stall, all forwards 00 until new valid producers enter the pipeline.
